// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus deglitcher for one raw PS/2 line.
// Outputs the filtered level and a one-cycle strobe on its 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic line_raw,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    // The idle PS/2 bus is high, so the chain resets high to avoid a false fall.
    logic [SYNC_STAGES-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_in or posedge reset) begin
                    if (reset) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= line_raw;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk_in or posedge reset) begin
                    if (reset) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic             synced;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             fall_reg;

    assign synced = sync_reg[SYNC_STAGES-1];

    // cnt_reg counts consecutive samples that disagree with the current level.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            fall_reg  <= 1'b0;
        end else begin
            fall_reg <= 1'b0;
            if (synced == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                level_reg <= synced;
                fall_reg  <= ~synced;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: frames bytes on filtered clock falls and flags bad frames.
// Optional macro PS2_BREAK_FILTER_EN suppresses F0 break prefixes and the key code that follows.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int TO_W        = 17
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       valid,
    output logic       frame_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic clk_fall;
    logic clk_level_unused;

    ps2_line_filter #(
        .FILTER_LEN  (FILTER_LEN),
        .SYNC_STAGES (2)
    ) u_clk_filter (
        .clk_in   (clk_in),
        .reset    (reset),
        .line_raw (ps2_clock),
        .level    (clk_level_unused),
        .fall     (clk_fall)
    );

    // Data only needs to be stable at the clock fall, so no deglitch here.
    logic [1:0] data_sync_reg;
    logic       data_sync;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            data_sync_reg <= 2'b11;
        end else begin
            data_sync_reg <= {data_sync_reg[0], ps2_data};
        end
    end

    assign data_sync = data_sync_reg[1];

    ps2_state_t      state_reg,    state_next;
    logic [2:0]      bitcnt_reg,   bitcnt_next;
    logic [7:0]      shift_reg,    shift_next;
    logic            parity_reg,   parity_next;
    logic [TO_W-1:0] to_cnt_reg,   to_cnt_next;
    logic [7:0]      scancode_reg;
    logic            valid_reg;
    logic            frame_err_reg;
    logic            accept;
    logic            err;
    logic            emit;

    always_comb begin
        state_next  = state_reg;
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        to_cnt_next = to_cnt_reg;
        accept      = 1'b0;
        err         = 1'b0;

        // A fall in the same cycle as terminal count takes priority.
        if (state_reg == IDLE || clk_fall) begin
            to_cnt_next = '0;
        end else if (to_cnt_reg == TO_LAST) begin
            to_cnt_next = '0;
            state_next  = IDLE;
            err         = 1'b1;
        end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end

        if (clk_fall) begin
            case (state_reg)
                IDLE: begin
                    if (!data_sync) begin
                        state_next  = DATA;
                        bitcnt_next = 3'd0;
                    end
                end
                DATA: begin
                    shift_next  = {data_sync, shift_reg[7:1]};
                    bitcnt_next = bitcnt_reg + 3'd1;
                    if (bitcnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = data_sync;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (data_sync && (^{shift_reg, parity_reg})) begin
                        accept = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic break_pend_reg, break_pend_next;

    // E0 prefixes pass through untouched so F0 E0 xx still hides only xx.
    always_comb begin
        emit            = accept;
        break_pend_next = break_pend_reg;
        if (err) begin
            break_pend_next = 1'b0;
        end else if (accept) begin
            if (shift_reg == PS2_BREAK) begin
                emit            = 1'b0;
                break_pend_next = 1'b1;
            end else if (shift_reg == PS2_EXT) begin
                emit = 1'b1;
            end else if (break_pend_reg) begin
                emit            = 1'b0;
                break_pend_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            break_pend_reg <= 1'b0;
        end else begin
            break_pend_reg <= break_pend_next;
        end
    end
`else
    always_comb begin
        emit = accept;
    end
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            bitcnt_reg    <= 3'd0;
            shift_reg     <= 8'h00;
            parity_reg    <= 1'b0;
            to_cnt_reg    <= '0;
            scancode_reg  <= 8'h00;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bitcnt_reg    <= bitcnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            to_cnt_reg    <= to_cnt_next;
            valid_reg     <= emit;
            frame_err_reg <= err;
            if (emit) begin
                scancode_reg <= shift_reg;
            end
        end
    end

    assign scancode  = scancode_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;

endmodule
